wb_burst_sram: RTL



---
 rtl/wb_pkg.sv | 43 ++++
 rtl/wb_if.sv | 22 ++
 rtl/wb_burst_sram_mem.sv | 38 +++
 rtl/wb_burst_sram.sv | 112 +++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone B4 types and the burst address sequencer,
// usable by both slave and master implementations.
package wb_pkg;

  typedef enum logic [2:0] {
    CLASSIC = 3'b000,
    CONST   = 3'b001,
    INCR    = 3'b010,
    EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    LINEAR = 2'b00,
    WRAP4  = 2'b01,
    WRAP8  = 2'b10,
    WRAP16 = 2'b11
  } bte_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACK  = 2'b01,
    ST_ERR  = 2'b10
  } state_e;

  function automatic logic cti_valid(input logic [2:0] cti);
    return (cti == CLASSIC) || (cti == INCR) || (cti == EOB);
  endfunction

  // Wrap modes advance only the low index bits; the caller truncates
  // the result to its own index width, so LINEAR wraps at the memory top.
  function automatic logic [31:0] wb_next_addr(input logic [31:0] a, input bte_e bte);
    logic [31:0] n;
    n = a;
    case (bte)
      WRAP4:   n[1:0] = a[1:0] + 2'd1;
      WRAP8:   n[2:0] = a[2:0] + 3'd1;
      WRAP16:  n[3:0] = a[3:0] + 4'd1;
      default: n      = a + 32'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 signal bundle with master and slave views.
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic [AW-1:0]   ADR;
  logic [DW-1:0]   DAT_W;
  logic [DW-1:0]   DAT_R;
  logic [DW/8-1:0] SEL;
  logic            CYC;
  logic            STB;
  logic            WE;
  logic [2:0]      CTI;
  logic [1:0]      BTE;
  logic            ACK;
  logic            ERR;

  modport master (output ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
                  input  DAT_R, ACK, ERR);
  modport slave  (input  ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
                  output DAT_R, ACK, ERR);
endinterface

// File: rtl/wb_burst_sram_mem.sv
// Single-port byte-enable RAM, read-first, synchronous read with a
// resettable output register that holds when no read is issued.
module wb_burst_sram_mem #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [ADDR_BITS-1:0]    addr_i,
  input  logic                    re_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_BITS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_burst_sram.sv
// Wishbone B4 registered-feedback SRAM slave: classic cycles, linear and
// wrapping incrementing bursts, ERR on reserved cycle types.
module wb_burst_sram
  import wb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic clk,
  input  logic rstn,
  wb_if.slave  s
);

  localparam int OB = $clog2(WB_DATA_WIDTH/8);

  state_e                   state_q;
  logic                     ack_q;
  logic                     err_q;
  logic                     we_q;
  logic [MEM_ADDR_BITS-1:0] a_q;

  logic [WB_ADDR_WIDTH-1:0] adr;
  logic                     unused_adr;
  logic [MEM_ADDR_BITS-1:0] word_idx;
  logic [MEM_ADDR_BITS-1:0] next_a;
  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic                     req;
  logic                     beat;
  logic                     burst_go;
  logic                     mem_we;
  logic                     mem_re;
  logic [WB_DATA_WIDTH-1:0] rdata;

  assign adr        = s.ADR;
  assign unused_adr = ^adr;
  assign word_idx   = adr[OB +: MEM_ADDR_BITS];
  assign next_a     = MEM_ADDR_BITS'(wb_next_addr(32'(a_q), bte_e'(s.BTE)));

  assign req      = s.CYC & s.STB;
  assign beat     = rstn & (state_q == ST_ACK) & req;
  assign burst_go = beat & (s.CTI == INCR);
  assign mem_we   = beat & we_q;
  // Write bursts never need the look-ahead read, which frees the single port.
  assign mem_re   = rstn & (((state_q == ST_IDLE) & req & cti_valid(s.CTI)) |
                            (burst_go & ~we_q));
  assign mem_addr = (state_q == ST_IDLE) ? word_idx : (mem_we ? a_q : next_a);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      a_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (req) begin
            if (cti_valid(s.CTI)) begin
              a_q     <= word_idx;
              we_q    <= s.WE;
              ack_q   <= 1'b1;
              state_q <= ST_ACK;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_ERR;
            end
          end
        end
        ST_ACK: begin
          if (burst_go) begin
            a_q <= next_a;
          end else begin
            ack_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_ERR: begin
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  wb_burst_sram_mem #(
    .ADDR_BITS  (MEM_ADDR_BITS),
    .DATA_WIDTH (WB_DATA_WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .addr_i  (mem_addr),
    .re_i    (mem_re),
    .we_i    (mem_we),
    .be_i    (s.SEL),
    .wdata_i (s.DAT_W),
    .rdata_o (rdata)
  );

  assign s.DAT_R = rdata;
  assign s.ACK   = ack_q & req;
  assign s.ERR   = err_q & req;

endmodule
